// File: rtl/boreal_vec_loader_pkg.sv
// boreal_vec_loader_pkg
//   Shared definitions for the vector-engine MMIO loader:
//   - engine register/scratchpad word addresses (11-bit MMIO word space)
//   - engine STATUS codes
//   - loader error codes reported on err
//   - loader FSM state encoding
package boreal_vec_loader_pkg;

  // Engine MMIO map (word addresses)
  localparam logic [10:0] VEC_CMD_ADDR    = 11'h000;
  localparam logic [10:0] VEC_LEN_ADDR    = 11'h001;
  localparam logic [10:0] VEC_STATUS_ADDR = 11'h009;
  localparam logic [10:0] VEC_A_BASE      = 11'h100;
  localparam logic [10:0] VEC_B_BASE      = 11'h300;
  localparam logic [10:0] VEC_OUT_BASE    = 11'h500;

  // Engine STATUS register values
  localparam logic [31:0] VEC_ST_BUSY = 32'd1;
  localparam logic [31:0] VEC_ST_DONE = 32'd2;

  // Loader error codes
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // Loader FSM states
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CHECK     = 4'd1,
    ST_IN_RD     = 4'd2,
    ST_IN_WAIT   = 4'd3,
    ST_IN_WR     = 4'd4,
    ST_SET_LEN   = 4'd5,
    ST_GO        = 4'd6,
    ST_SETTLE1   = 4'd7,
    ST_SETTLE2   = 4'd8,
    ST_POLL_ADDR = 4'd9,
    ST_POLL_CHK  = 4'd10,
    ST_OUT_ADDR  = 4'd11,
    ST_OUT_CAP   = 4'd12,
    ST_OUT_WR    = 4'd13,
    ST_FINISH    = 4'd14
  } state_e;

endpackage

// File: rtl/boreal_vec_loader.sv
// boreal_vec_loader
//   MMIO initiator that runs one vector-engine job per host descriptor:
//   copies packed int8 vectors A and B from system memory into the engine
//   scratchpad, programs LEN, fires CMD, polls STATUS until done, then copies
//   the 32-bit OUT products back to system memory.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle pulse, accepted only when idle
//   desc_a_base/_b_base   memory word addresses of packed A / B
//   desc_out_base         memory word address for results
//   desc_len              element count (multiple of 8, 1..MAX_LEN)
//   busy, done, err       run status; err held until the next start
//   mem_*                 system-memory initiator (req/gnt, rvalid read return)
//   mmio_*                engine MMIO slave port (registered read data)
module boreal_vec_loader
  import boreal_vec_loader_pkg::*;
#(
  parameter int AW       = 20,
  parameter int MAX_LEN  = 768,
  parameter int POLL_MAX = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] desc_a_base,
  input  logic [AW-1:0] desc_b_base,
  input  logic [AW-1:0] desc_out_base,
  input  logic [31:0]   desc_len,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          mmio_we,
  output logic [10:0]   mmio_addr,
  output logic [31:0]   mmio_wdata,
  output logic [3:0]    mmio_wstrb,
  input  logic [31:0]   mmio_rdata
);

  localparam int PCW = $clog2(POLL_MAX + 1);

  state_e state_q, state_d;

  // Descriptor, captured on an accepted start
  logic [AW-1:0] a_base_q, b_base_q, out_base_q;
  logic [31:0]   len_q;

  // Progress counters
  logic [9:0]     k_q;       // word index within the vector being copied in
  logic           vec_b_q;   // 0: copying A, 1: copying B
  logic [9:0]     j_q;       // element index of the output copy
  logic [PCW-1:0] poll_q;    // completed STATUS polls

  logic [1:0]  err_q;
  logic [31:0] mmio_wdata_q; // holds its value between MMIO writes
  logic [31:0] out_word_q;   // product read back from OUT scratchpad

  logic [9:0] last_k;
  logic [9:0] last_j;

  // len is a multiple of 8 and at most MAX_LEN once validated, so the
  // 10-bit word/element counters never overflow.
  assign last_k = len_q[11:2] - 10'd1;
  assign last_j = len_q[9:0] - 10'd1;

  function automatic logic len_bad(input logic [31:0] len);
    return (len == 32'd0) || (len[2:0] != 3'd0) || (len > 32'(MAX_LEN));
  endfunction

  // State register and control counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      vec_b_q      <= 1'b0;
      j_q          <= '0;
      poll_q       <= '0;
      err_q        <= ERR_OK;
      mmio_wdata_q <= '0;
      out_word_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            err_q   <= ERR_OK;
            k_q     <= '0;
            vec_b_q <= 1'b0;
            j_q     <= '0;
            poll_q  <= '0;
          end
        end
        ST_CHECK: begin
          if (len_bad(len_q)) err_q <= ERR_LEN;
        end
        ST_IN_WAIT: begin
          if (mem_rvalid) mmio_wdata_q <= mem_rdata;
        end
        ST_IN_WR: begin
          if (k_q == last_k) begin
            k_q     <= '0;
            vec_b_q <= 1'b1;
            // Last B word: stage LEN as the next MMIO write data
            if (vec_b_q) mmio_wdata_q <= len_q;
          end else begin
            k_q <= k_q + 10'd1;
          end
        end
        ST_SET_LEN: mmio_wdata_q <= 32'd1;
        ST_POLL_CHK: begin
          if (mmio_rdata != VEC_ST_DONE) begin
            poll_q <= poll_q + 1'b1;
            if (poll_q == PCW'(POLL_MAX - 1)) err_q <= ERR_TIMEOUT;
          end
        end
        ST_OUT_CAP: out_word_q <= mmio_rdata;
        ST_OUT_WR: begin
          if (mem_gnt) j_q <= j_q + 10'd1;
        end
        default: ;
      endcase
    end
  end

  // Descriptor capture (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && start) begin
      a_base_q   <= desc_a_base;
      b_base_q   <= desc_b_base;
      out_base_q <= desc_out_base;
      len_q      <= desc_len;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (start) state_d = ST_CHECK;
      ST_CHECK:     state_d = len_bad(len_q) ? ST_FINISH : ST_IN_RD;
      ST_IN_RD:     if (mem_gnt) state_d = ST_IN_WAIT;
      ST_IN_WAIT:   if (mem_rvalid) state_d = ST_IN_WR;
      ST_IN_WR:     state_d = (vec_b_q && k_q == last_k) ? ST_SET_LEN : ST_IN_RD;
      ST_SET_LEN:   state_d = ST_GO;
      ST_GO:        state_d = ST_SETTLE1;
      // The engine picks up CMD a cycle after the write and updates STATUS
      // a cycle later; polling earlier would read the previous run's DONE.
      ST_SETTLE1:   state_d = ST_SETTLE2;
      ST_SETTLE2:   state_d = ST_POLL_ADDR;
      ST_POLL_ADDR: state_d = ST_POLL_CHK;
      ST_POLL_CHK: begin
        if (mmio_rdata == VEC_ST_DONE)            state_d = ST_OUT_ADDR;
        else if (poll_q == PCW'(POLL_MAX - 1))    state_d = ST_FINISH;
        else                                      state_d = ST_POLL_ADDR;
      end
      ST_OUT_ADDR:  state_d = ST_OUT_CAP;
      ST_OUT_CAP:   state_d = ST_OUT_WR;
      ST_OUT_WR:    if (mem_gnt) state_d = (j_q == last_j) ? ST_FINISH : ST_OUT_ADDR;
      ST_FINISH:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state so reset clears them without a clock edge
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mmio_we   = 1'b0;
    mmio_addr = '0;
    unique case (state_q)
      ST_IDLE: ;
      ST_CHECK, ST_IN_WAIT, ST_SETTLE1, ST_SETTLE2, ST_POLL_CHK: busy = 1'b1;
      ST_IN_RD: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = (vec_b_q ? b_base_q : a_base_q) + AW'(k_q);
      end
      ST_IN_WR: begin
        busy      = 1'b1;
        mmio_we   = 1'b1;
        mmio_addr = (vec_b_q ? VEC_B_BASE : VEC_A_BASE) + 11'(k_q);
      end
      ST_SET_LEN: begin
        busy      = 1'b1;
        mmio_we   = 1'b1;
        mmio_addr = VEC_LEN_ADDR;
      end
      ST_GO: begin
        busy      = 1'b1;
        mmio_we   = 1'b1;
        mmio_addr = VEC_CMD_ADDR;
      end
      ST_POLL_ADDR: begin
        busy      = 1'b1;
        mmio_addr = VEC_STATUS_ADDR;
      end
      ST_OUT_ADDR, ST_OUT_CAP: begin
        busy      = 1'b1;
        mmio_addr = VEC_OUT_BASE + 11'(j_q);
      end
      ST_OUT_WR: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = out_base_q + AW'(j_q);
      end
      ST_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  assign err        = err_q;
  assign mmio_wdata = mmio_wdata_q;
  assign mmio_wstrb = mmio_we ? 4'hF : 4'h0;
  assign mem_wdata  = out_word_q;

endmodule

// File: tb/tb_boreal_vec_loader.sv
`timescale 1ns/1ps
module tb_boreal_vec_loader;
  import boreal_vec_loader_pkg::*;

  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] desc_a_base = '0, desc_b_base = '0, desc_out_base = '0;
  logic [31:0]   desc_len = '0;
  logic          busy, done;
  logic [1:0]    err;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          mmio_we;
  logic [10:0]   mmio_addr;
  logic [31:0]   mmio_wdata;
  logic [3:0]    mmio_wstrb;
  logic [31:0]   mmio_rdata = '0;

  always #5 clk = ~clk;

  boreal_vec_loader #(.AW(AW), .MAX_LEN(768), .POLL_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .desc_a_base(desc_a_base), .desc_b_base(desc_b_base),
    .desc_out_base(desc_out_base), .desc_len(desc_len),
    .busy(busy), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mmio_we(mmio_we), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_wstrb(mmio_wstrb), .mmio_rdata(mmio_rdata)
  );

  // Behavioural system memory: grant after gnt_dly waiting cycles,
  // read data rv_dly cycles after the grant.
  logic [31:0] mem [0:1023];
  int          gnt_dly = 0, rv_dly = 1, wait_cnt = 0, rv_cnt = 0;
  logic        rv_pend = 1'b0;
  logic [31:0] rv_data = '0;
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  assign mem_gnt = mem_req && (wait_cnt >= gnt_dly);

  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (ld_en) mem[ld_addr] <= ld_data;
    if (mem_req && !mem_gnt) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (mem_gnt) begin
      if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
      else if (rv_dly <= 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mem[mem_addr[9:0]];
      end else begin
        rv_pend <= 1'b1;
        rv_cnt  <= rv_dly - 2;
        rv_data <= mem[mem_addr[9:0]];
      end
    end else if (rv_pend) begin
      if (rv_cnt == 0) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= rv_data;
        rv_pend    <= 1'b0;
      end else begin
        rv_cnt <= rv_cnt - 1;
      end
    end
  end

  // Behavioural vector engine: registered reads, CMD seen a cycle after the
  // write, STATUS busy the cycle after that, done after len/8+1 more cycles.
  // eng_stuck keeps STATUS at busy forever.
  logic [31:0] sp [0:2047];
  logic [31:0] eng_status = '0, eng_len = '0;
  logic        cmd_pend = 1'b0, eng_stuck = 1'b0;
  int          run_cnt = -1;

  always @(posedge clk) begin
    logic signed [7:0] ea, eb;
    int pa, pb;
    mmio_rdata <= (mmio_addr == VEC_STATUS_ADDR) ? eng_status : sp[mmio_addr];
    if (cmd_pend) begin
      cmd_pend   <= 1'b0;
      eng_status <= VEC_ST_BUSY;
      run_cnt    <= int'(eng_len / 8) + 1;
    end else if (run_cnt > 0) begin
      run_cnt <= run_cnt - 1;
    end else if (run_cnt == 0) begin
      for (int i = 0; i < int'(eng_len); i++) begin
        ea = sp[256 + i / 4][8 * (i % 4) +: 8];
        eb = sp[768 + i / 4][8 * (i % 4) +: 8];
        pa = ea;
        pb = eb;
        sp[1280 + i] <= pa * pb;
      end
      if (!eng_stuck) eng_status <= VEC_ST_DONE;
      run_cnt <= -1;
    end
    if (mmio_we && mmio_wstrb == 4'hF) begin
      if (mmio_addr == VEC_CMD_ADDR)      cmd_pend <= mmio_wdata[0];
      else if (mmio_addr == VEC_LEN_ADDR) eng_len  <= mmio_wdata;
      else                                sp[mmio_addr] <= mmio_wdata;
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0]   len;
    logic [AW-1:0] a_base;
    logic [31:0]   a0, a1, b0, b1;
    int            gnt_dly, rv_dly;
    logic          stuck;
    logic [1:0]    exp_err;
    logic [31:0]   exp_out [8];
  } vec_t;

  localparam int NV = 9;
  vec_t vt [NV];

  localparam logic [AW-1:0] B_BASE   = 20'h00020;
  localparam logic [AW-1:0] OUT_BASE = 20'h00040;

  // Called at a negedge; the write lands on the following posedge
  task automatic ld(input logic [9:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic preload(input int i);
    logic [AW-1:0] p;
    p = vt[i].a_base;          ld(p[9:0], vt[i].a0);
    p = vt[i].a_base + 20'd1;  ld(p[9:0], vt[i].a1);
    p = B_BASE;                ld(p[9:0], vt[i].b0);
    p = B_BASE + 20'd1;        ld(p[9:0], vt[i].b1);
    for (int j = 0; j < 8; j++) begin
      p = OUT_BASE + AW'(j);
      ld(p[9:0], 32'hDEADBEEF);
    end
  endtask

  task automatic run_vec(input int i);
    int cyc, done_n, done_cyc, wr_pre, polls, traffic, out_rd, stab, post;
    logic seen, prev_hold, prev_we;
    logic [AW-1:0] prev_addr;
    preload(i);
    gnt_dly = vt[i].gnt_dly;
    rv_dly  = vt[i].rv_dly;
    eng_stuck = vt[i].stuck;
    desc_a_base = vt[i].a_base;
    desc_b_base = B_BASE;
    desc_out_base = OUT_BASE;
    desc_len = vt[i].len;
    start = 1'b1;
    cyc = 0; done_n = 0; done_cyc = 0; wr_pre = 0; polls = 0; traffic = 0;
    out_rd = 0; stab = 0; post = 0; seen = 1'b0; prev_hold = 1'b0;
    prev_we = 1'b0; prev_addr = '0;
    while (post < 3 && cyc < 3000) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (mmio_we && polls == 0) wr_pre++;
      if (mmio_we || mem_req) traffic++;
      if (!mmio_we && mmio_addr == VEC_STATUS_ADDR) polls++;
      if (!mmio_we && mmio_addr >= VEC_OUT_BASE) out_rd++;
      if (prev_hold && (mem_addr !== prev_addr || mem_we !== prev_we)) stab++;
      prev_hold = mem_req && !mem_gnt;
      prev_addr = mem_addr;
      prev_we   = mem_we;
      if (done) begin
        done_n++;
        if (!seen) done_cyc = cyc;
        seen = 1'b1;
      end else if (seen) begin
        post++;
      end
    end
    chk($sformatf("v%0d_done_seen", i), 32'(seen), 32'd1);
    chk($sformatf("v%0d_done_pulses", i), 32'(done_n), 32'd1);
    chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].exp_err));
    chk($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
    if (vt[i].exp_err == ERR_OK) begin
      chk($sformatf("v%0d_writes_before_poll", i), 32'(wr_pre), 32'd6);
      chk($sformatf("v%0d_addr_stable", i), 32'(stab), 32'd0);
      for (int j = 0; j < 8; j++)
        chk($sformatf("v%0d_out%0d", i, j), mem[int'(OUT_BASE[9:0]) + j], vt[i].exp_out[j]);
    end else if (vt[i].exp_err == ERR_LEN) begin
      chk($sformatf("v%0d_done_latency", i), 32'(done_cyc), 32'd2);
      chk($sformatf("v%0d_traffic", i), 32'(traffic), 32'd0);
    end else begin
      chk($sformatf("v%0d_polls", i), 32'(polls), 32'd16);
      chk($sformatf("v%0d_out_reads", i), 32'(out_rd), 32'd0);
    end
  endtask

  initial begin
    int cnt;
    vt[0] = '{len: 32'd8, a_base: 20'h00010, a0: 32'h04030201, a1: 32'h08070605,
              b0: 32'h02020202, b1: 32'h02020202, gnt_dly: 0, rv_dly: 1, stuck: 1'b0,
              exp_err: ERR_OK, exp_out: '{32'd2, 32'd4, 32'd6, 32'd8, 32'd10, 32'd12, 32'd14, 32'd16}};
    vt[1] = '{len: 32'd8, a_base: 20'h00010, a0: 32'h00000080, a1: 32'h0,
              b0: 32'h0000007F, b1: 32'h0, gnt_dly: 0, rv_dly: 1, stuck: 1'b0,
              exp_err: ERR_OK, exp_out: '{32'hFFFFC080, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}};
    vt[2] = vt[0];
    vt[2].gnt_dly = 5;
    vt[2].rv_dly  = 3;
    vt[3] = vt[0];
    vt[3].len = 32'd12;
    vt[3].exp_err = ERR_LEN;
    vt[4] = vt[3];
    vt[4].len = 32'd0;
    vt[5] = vt[3];
    vt[5].len = 32'd776;
    vt[6] = '{len: 32'd8, a_base: 20'h00010, a0: 32'h7F03FEFF, a1: 32'h80808080,
              b0: 32'h80FF0203, b1: 32'h80808080, gnt_dly: 1, rv_dly: 2, stuck: 1'b0,
              exp_err: ERR_OK, exp_out: '{32'hFFFFFFFD, 32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFC080,
                                          32'h00004000, 32'h00004000, 32'h00004000, 32'h00004000}};
    vt[7] = vt[0];
    vt[7].stuck = 1'b1;
    vt[7].exp_err = ERR_TIMEOUT;
    vt[8] = vt[0];
    vt[8].a_base = 20'hFFFFF;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mmio_we", 32'(mmio_we), 32'd0);
    chk("rst_mmio_addr", 32'(mmio_addr), 32'd0);
    chk("rst_mmio_wdata", mmio_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Reset in the middle of the input copy
    preload(0);
    gnt_dly = 5;
    rv_dly = 3;
    eng_stuck = 1'b0;
    desc_a_base = vt[0].a_base;
    desc_b_base = B_BASE;
    desc_out_base = OUT_BASE;
    desc_len = 32'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy_before", 32'(busy), 32'd1);
    chk("mid_req_before", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy_async", 32'(busy), 32'd0);
    chk("mid_req_async", 32'(mem_req), 32'd0);
    chk("mid_we_async", 32'(mmio_we), 32'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (mmio_we || mem_req || busy) cnt++;
    end
    chk("mid_quiet_in_reset", 32'(cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
